// File: rtl/adder_sched_pkg.sv
// Shared helpers for the round-robin adder scheduler.
package adder_sched_pkg;

    // Index width for n requesters, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/adder.sv
// Plain combinational adder with carry out; the one arithmetic unit being shared.
module adder #(
    parameter int unsigned SIZE = 32
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE-1:0] sum,
    output logic            carry
);

    // Add at SIZE+1 bits so the carry out of the top bit is kept.
    always_comb begin
        {carry, sum} = {1'b0, a} + {1'b0, b};
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant from a request vector, pointer advances on grant.
module rr_arbiter
    import adder_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W   = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic [ID_W-1:0] ptr_q;
    logic            any_req;
    int unsigned     idx;

    // Scan ptr, ptr+1, ... wrapping; the first requester found wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_req && req[idx]) begin
                any_req   = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
        if (enable && any_req) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Pointer moves just past the winner, only when a grant is actually taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (enable && any_req) begin
            ptr_q <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Shares one adder between NUM_REQ requesters with round-robin arbitration and a
// single registered valid/ready response stage.
module adder_rr_scheduler
    import adder_sched_pkg::*;
#(
    parameter int unsigned SIZE    = 32,
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W   = id_width(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*SIZE-1:0] req_a,
    input  logic [NUM_REQ*SIZE-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [SIZE-1:0]         rsp_sum,
    output logic                    rsp_overflow
);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [SIZE-1:0] sum;
        logic            overflow;
    } rsp_t;

    rsp_t            rsp_q;
    logic            rsp_valid_q;
    logic            can_accept;
    logic            accept;
    logic [ID_W-1:0] grant_idx;
    logic [SIZE-1:0] op_a;
    logic [SIZE-1:0] op_b;
    logic [SIZE-1:0] add_sum;
    logic            add_carry;

    // Nothing is accepted during reset so no requester sees a phantom handshake.
    assign can_accept = !reset && (!rsp_valid_q || rsp_ready);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arbiter (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .enable    (can_accept),
        .grant     (req_ready),
        .grant_idx (grant_idx)
    );

    // Grant is already qualified by req_valid, so any ready bit is an accept.
    assign accept = |req_ready;

    // Steer the winner's operands into the shared adder.
    always_comb begin
        op_a = req_a[int'(grant_idx) * SIZE +: SIZE];
        op_b = req_b[int'(grant_idx) * SIZE +: SIZE];
    end

    adder #(
        .SIZE (SIZE)
    ) u_adder (
        .a     (op_a),
        .b     (op_b),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // Output stage: load on accept, drain on consume, otherwise hold bit-stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else if (accept) begin
            rsp_valid_q    <= 1'b1;
            rsp_q.id       <= grant_idx;
            rsp_q.sum      <= add_sum;
            rsp_q.overflow <= add_carry;
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_q.id;
    assign rsp_sum      = rsp_q.sum;
    assign rsp_overflow = rsp_q.overflow;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed bench for adder_rr_scheduler with SIZE=8, NUM_REQ=4.
module tb_adder_rr_scheduler;

    localparam int unsigned SIZE    = 8;
    localparam int unsigned NUM_REQ = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*SIZE-1:0] req_a;
    logic [NUM_REQ*SIZE-1:0] req_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [1:0]              rsp_id;
    logic [SIZE-1:0]         rsp_sum;
    logic                    rsp_overflow;

    int passed = 0;
    int total  = 0;

    adder_rr_scheduler #(
        .SIZE    (SIZE),
        .NUM_REQ (NUM_REQ)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_sum      (rsp_sum),
        .rsp_overflow (rsp_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*SIZE +: SIZE] = a;
        req_b[i*SIZE +: SIZE] = b;
    endtask

    task automatic check_rsp(input string tag, input logic [1:0] id, input logic [7:0] sum,
                             input logic ov);
        check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".id"}, 32'(rsp_id), 32'(id));
        check({tag, ".sum"}, 32'(rsp_sum), 32'(sum));
        check({tag, ".ovf"}, 32'(rsp_overflow), 32'(ov));
    endtask

    initial begin
        // 1: reset with every requester asking
        reset     = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("reset_ready", 32'(req_ready), 32'h0);
        end
        reset     = 1'b0;
        req_valid = 4'h0;
        #1;
        check("post_reset_valid", 32'(rsp_valid), 32'd0);
        check("post_reset_sum", 32'(rsp_sum), 32'd0);
        check("post_reset_id", 32'(rsp_id), 32'd0);
        check("post_reset_ovf", 32'(rsp_overflow), 32'd0);

        // 2: single requester 2, 7F+01
        req_valid = 4'b0100;
        set_ops(2, 8'h7F, 8'h01);
        #1;
        check("t2_ready", 32'(req_ready), 32'b0100);
        tick();
        check_rsp("t2", 2'd2, 8'h80, 1'b0);

        // 3: carry out, then zero
        set_ops(2, 8'hFF, 8'h02);
        tick();
        check_rsp("t3_carry", 2'd2, 8'h01, 1'b1);
        set_ops(2, 8'h00, 8'h00);
        tick();
        check_rsp("t3_zero", 2'd2, 8'h00, 1'b0);

        // Pointer now 3; take requester 3 alone so the pointer wraps to 0.
        req_valid = 4'b1000;
        set_ops(3, 8'h31, 8'h01);
        tick();
        check_rsp("t4_wrap", 2'd3, 8'h32, 1'b0);

        // 4: all valid back to back
        set_ops(0, 8'h01, 8'h01);
        set_ops(1, 8'h11, 8'h01);
        set_ops(2, 8'h21, 8'h01);
        req_valid = 4'hF;
        tick();
        check_rsp("t4_c0", 2'd0, 8'h02, 1'b0);
        tick();
        check_rsp("t4_c1", 2'd1, 8'h12, 1'b0);
        tick();
        check_rsp("t4_c2", 2'd2, 8'h22, 1'b0);
        tick();
        check_rsp("t4_c3", 2'd3, 8'h32, 1'b0);
        tick();
        check_rsp("t4_c4", 2'd0, 8'h02, 1'b0);
        tick();
        check_rsp("t4_c5", 2'd1, 8'h12, 1'b0);

        // 5: backpressure for 5 cycles, then same-cycle reload
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        set_ops(1, 8'h40, 8'h05);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("t5_stall_ready", 32'(req_ready), 32'h0);
            tick();
            check_rsp("t5_hold", 2'd1, 8'h12, 1'b0);
        end
        rsp_ready = 1'b1;
        #1;
        check("t5_reload_ready", 32'(req_ready), 32'b0010);
        tick();
        check_rsp("t5_reload", 2'd1, 8'h45, 1'b0);

        // 6: reset while a result is pending
        rsp_ready = 1'b0;
        req_valid = 4'h0;
        reset     = 1'b1;
        tick();
        check("t6_flush_valid", 32'(rsp_valid), 32'd0);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b1001;
        set_ops(0, 8'h0A, 8'h0B);
        set_ops(3, 8'hF0, 8'h20);
        #1;
        check("t6_ready", 32'(req_ready), 32'b0001);
        tick();
        check_rsp("t6_first", 2'd0, 8'h15, 1'b0);
        tick();
        check_rsp("t6_second", 2'd3, 8'h10, 1'b1);
        req_valid = 4'h0;
        tick();
        check("t6_drain", 32'(rsp_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
